// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with registered result flags
// and a wrapping count of completed output handshakes.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] done_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_y;
    logic             s2_valid;
    logic             s1_load;
    logic             s2_load;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] op_y;

    // Each stage may take new data when empty or when draining downstream
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid && out_ready;
    assign out_valid = s2_valid;

    always_comb begin
        op_y = '0;
        unique case (in_op)
            3'd0: op_y = in_a & in_b;
            3'd1: op_y = in_a | in_b;
            3'd2: op_y = in_a ^ in_b;
            3'd3: op_y = ~(in_a & in_b);
            3'd4: op_y = ~(in_a | in_b);
            3'd5: op_y = ~(in_a ^ in_b);
            3'd6: op_y = ~in_a;
            3'd7: op_y = in_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_fire)
                s1_y <= op_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_y      <= '0;
            out_zero   <= 1'b1;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_y      <= s1_y;
                out_zero   <= ~|s1_y;
                out_ones   <= &s1_y;
                out_parity <= ^s1_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            done_count <= '0;
        else if (out_fire)
            done_count <= done_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8, CNT_W=4 so the
// completion counter wraps within a short run).
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_ones;
    logic             out_parity;
    logic [CNT_W-1:0] done_count;

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity),
        .done_count (done_count)
    );

    typedef struct {
        logic [WIDTH-1:0] y;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_out = 0;
    bit   mon_en = 0;
    bit   chk_lat = 0;
    bit   stop = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // Handshakes complete at the next rising edge; both sides are
    // stable at the falling edge, so score them there.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 32'(out_y), 32'hx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_y", 32'(out_y), 32'(e.y));
                    check("out_zero", 32'(out_zero),
                          32'(e.y == '0));
                    check("out_ones", 32'(out_ones),
                          32'(e.y == '1));
                    check("out_parity", 32'(out_parity),
                          32'(^e.y));
                    if (chk_lat)
                        check("latency", cyc - e.cyc, 2);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.y   = model(in_a, in_b, in_op);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b,
                        input logic [2:0] op);
        bit ok;
        ok = 0;
        in_a = a;
        in_b = b;
        in_op = op;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok)
            check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0 && !out_valid)
                break;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_y", 32'(out_y), 0);
        check("rst_zero", 32'(out_zero), 1);
        check("rst_ones", 32'(out_ones), 0);
        check("rst_parity", 32'(out_parity), 0);
        check("rst_count", 32'(done_count), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1;

        // Opcode sweep, back to back, with latency checking
        out_ready = 1'b1;
        chk_lat = 1;
        for (int op = 0; op < 8; op++)
            send(8'hCA, 8'h5F, 3'(op));
        drain();
        chk_lat = 0;
        check("sweep_count", 32'(done_count), 8);

        // Flag corner cases
        send(8'hF0, 8'h0F, 3'd0);
        send(8'hF0, 8'h0F, 3'd1);
        send(8'h01, 8'h00, 3'd7);
        drain();

        // Backpressure: capacity of two, then same-cycle recovery
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_a = 8'h11; in_b = 8'hFF; in_op = 3'd0;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_acc1", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_a = 8'h0F; in_b = 8'hF0; in_op = 3'd2;
        @(negedge clk);
        check("bp_acc2", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_a = 8'h00; in_b = 8'h22; in_op = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_full", 32'(in_ready), 0);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_hold", 32'(out_y), 32'h11);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("bp_recover", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check("bp_total", n_out, 14);

        // Random operands with random stalls on both sides
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    send(8'($urandom), 8'($urandom),
                         3'($urandom_range(0, 7)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("rand_total", n_out, 1014);
        check("rand_count", 32'(done_count), 32'(CNT_W'(n_out)));

        // Async reset with both stages full
        out_ready = 1'b0;
        send(8'h33, 8'h44, 3'd1);
        send(8'h55, 8'h66, 3'd2);
        check("full_valid", 32'(out_valid), 1);
        check("full_ready", 32'(in_ready), 0);
        mon_en = 0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_y", 32'(out_y), 0);
        check("arst_zero", 32'(out_zero), 1);
        check("arst_count", 32'(done_count), 0);
        check("arst_ready", 32'(in_ready), 1);
        q.delete();
        n_out = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1;
        out_ready = 1'b1;
        send(8'h00, 8'h00, 3'd4);
        drain();
        check("post_rst_count", 32'(done_count), 1);

        // Counter wrap at 2^CNT_W
        for (int i = 0; i < 14; i++)
            send(8'(i), 8'hA5, 3'(i % 8));
        drain();
        check("wrap_15", 32'(done_count), 15);
        send(8'h3C, 8'hC3, 3'd2);
        drain();
        check("wrap_0", 32'(done_count), 0);
        send(8'h3C, 8'hC3, 3'd5);
        drain();
        check("wrap_1", 32'(done_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got %0d exp 0", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit. Applies one of eight selectable gate operations to two WIDTH-bit operands per transaction, then registers result flags. Uses valid/ready handshakes on both sides and counts completed transactions. Sits between an operand source and a result consumer in the datapath, replacing fixed single-bit combinational gates with a throughput-matched, stallable stage.

## Interface
- WIDTH, 8, operand/result bit width (≥1)
- CNT_W, 16, width of completed-transaction counter (≥1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transaction present
- in_ready  output  1  block accepts transaction this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  operation select
- out_valid  output  1  result transaction present
- out_ready  input  1  consumer accepts result this cycle
- out_y  output  WIDTH  result
- out_zero  output  1  out_y == 0
- out_ones  output  1  out_y all ones
- out_parity  output  1  XOR-reduction of out_y
- done_count  output  CNT_W  number of completed output handshakes

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND (~(a&b)), 4 NOR (~(a|b)), 5 XNOR, 6 NOT_A (~a, b ignored), 7 PASS_A.
- Input handshake: in_valid & in_ready; output handshake: out_valid & out_ready.
- Stage 1 (S1): on input handshake, register y = op(in_a, in_b) and set s1_valid.
- Stage 2 (S2): on S1→S2 transfer, register y, then zero/ones/parity computed from the S1 y. Flags are registered, not combinational from out_y.
- out_valid = s2_valid; out_y and flags driven by S2 registers.
- Stage advance: S2 loads when (!s2_valid | out_ready); S1 loads when (!s1_valid | S2 loads). in_ready = !s1_valid | S2 loads. in_ready must not depend combinationally on in_valid.
- A stage not loaded and not drained holds data and flags unchanged (stall).
- Simultaneous drain and fill of a stage in the same cycle: the new data replaces the old. No bubble and no loss.
- done_count increments by 1 on each output handshake. It wraps 2^CNT_W−1 → 0.
- Reset (async assert, any cycle, mid-transaction included): s1_valid=0, s2_valid=0, out_valid=0, in_ready=1 (combinational from cleared state), out_y=0, out_zero=1, out_ones=0, out_parity=0, done_count=0. In-flight transactions are discarded. Deassertion is synchronous to clk.

## Timing
- Latency: 2 cycles. A transaction accepted at edge N is visible on out_* after edge N+1, with out_valid high in cycle N+1→N+2.
- Throughput: 1 transaction/cycle while out_ready is held high.
- Capacity: 2 transactions. With out_ready low, in_ready drops after two accepted transactions.
- in_ready recovers in the same cycle out_ready rises (combinational path out_ready→in_ready).
- out_* stable while out_valid & !out_ready.
- WIDTH=1: out_zero = ~out_y, out_ones = out_y, out_parity = out_y.

## Test plan
- Opcode sweep, WIDTH=8, out_ready=1: a=8'hCA, b=8'h5F, ops 0..7 back-to-back → out_y = 4A, DF, 95, B5, 20, 6A, 35, CA on consecutive cycles, 2 cycles after each input. done_count ends at 8.
- Flags: AND a=8'hF0,b=8'h0F → y=00, zero=1, ones=0, parity=0. OR same operands → y=FF, zero=0, ones=1, parity=0. PASS_A a=8'h01 → parity=1.
- Backpressure: out_ready=0, offer 3 transactions → first two accepted, in_ready=0 on third. Outputs hold the first result. Raise out_ready → in_ready=1 in that cycle, order preserved, no duplicates or drops.
- Random stall: 1000 random operands/ops with random in_valid/out_ready → scoreboard matches in order; done_count equals output handshakes mod 2^CNT_W.
- Counter wrap with CNT_W=4: 17 completed transactions → done_count sequence reaches 15 then 0, ends at 1.
- Async reset mid-stream: assert rst_n=0 between edges with both stages full → out_valid=0, out_y=0, out_zero=1, done_count=0 immediately without a clock edge. After release, a first transaction (NOR a=0, b=0) → out_y=FF.
